// File: rtl/doll_if.sv
// Player-side signal bundle for the doll sequencer: game controls, sensor inputs and status outputs.
interface doll_if;
  logic       start;
  logic       abort;
  logic       motion;
  logic       goal;
  logic       turn;
  logic       facing;
  logic [2:0] state;
  logic [3:0] round;
  logic       caught;
  logic       win;

  modport master (
    output start, abort, motion, goal,
    input  turn, facing, state, round, caught, win
  );

  modport slave (
    input  start, abort, motion, goal,
    output turn, facing, state, round, caught, win
  );
endinterface

// File: rtl/doll_sequencer.sv
// Game sequencer for the singing doll: sing / turn / watch rounds with motion capture,
// goal detection, abort handling and homing of the head to its back-facing rest position.
//
// state  | meaning
// IDLE   | waiting for start; head at rest (back to players)
// SING   | doll sings, players may move; random duration
// TURN_F | head travelling toward players; motion ignored
// WATCH  | doll faces players; any motion loses the game
// TURN_B | head travelling back; next round follows
// CAUGHT | game lost; waits for start acknowledge or abort
// WIN    | game won; waits for start acknowledge or abort
// HOME   | head returning to rest after a game
module doll_sequencer #(
  parameter int unsigned SING_BASE  = 200_000_000,
  parameter int unsigned SING_SHIFT = 24,
  parameter int unsigned TRAVEL     = 20_000_000,
  parameter int unsigned WATCH      = 300_000_000,
  parameter int unsigned ROUNDS     = 5
) (
  input  logic clk,
  input  logic rst,
  doll_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SING   = 3'd1,
    S_TURN_F = 3'd2,
    S_WATCH  = 3'd3,
    S_TURN_B = 3'd4,
    S_CAUGHT = 3'd5,
    S_WIN    = 3'd6,
    S_HOME   = 3'd7
  } state_t;

  localparam logic [31:0] TRAVEL_L = 32'(TRAVEL);
  localparam logic [31:0] WATCH_L  = 32'(WATCH);
  localparam logic [3:0]  ROUNDS_L = 4'(ROUNDS);

  state_t      cur, nxt;
  logic [31:0] timer, timer_nxt;
  logic [15:0] lfsr;
  logic [3:0]  round_r, round_nxt;
  logic        facing_r, facing_nxt;
  logic        caught_r, caught_nxt;
  logic        win_r, win_nxt;
  logic        turn;
  logic        leave;
  logic        tz;
  logic [31:0] sing_load;

  assign tz        = (timer == 32'd0);
  assign sing_load = 32'(SING_BASE) + ({28'd0, lfsr[3:0]} << SING_SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur      <= S_IDLE;
      timer    <= 32'd0;
      lfsr     <= 16'hACE1;
      round_r  <= 4'd0;
      facing_r <= 1'b0;
      caught_r <= 1'b0;
      win_r    <= 1'b0;
    end else begin
      cur      <= nxt;
      timer    <= timer_nxt;
      lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      round_r  <= round_nxt;
      facing_r <= facing_nxt;
      caught_r <= caught_nxt;
      win_r    <= win_nxt;
    end
  end

  always_comb begin
    nxt        = cur;
    timer_nxt  = tz ? 32'd0 : timer - 32'd1;
    round_nxt  = round_r;
    facing_nxt = facing_r;
    caught_nxt = caught_r;
    win_nxt    = win_r;
    turn       = 1'b0;
    leave      = 1'b0;

    if (bus.abort && cur != S_IDLE && cur != S_HOME) begin
      leave      = 1'b1;
      caught_nxt = 1'b0;
      win_nxt    = 1'b0;
    end else begin
      case (cur)
        S_IDLE: if (bus.start) begin
          nxt        = S_SING;
          round_nxt  = 4'd1;
          caught_nxt = 1'b0;
          win_nxt    = 1'b0;
          timer_nxt  = sing_load;
        end
        S_SING: begin
          if (bus.goal) begin
            nxt     = S_WIN;
            win_nxt = 1'b1;
          end else if (tz) begin
            nxt       = S_TURN_F;
            turn      = 1'b1;
            timer_nxt = TRAVEL_L;
          end
        end
        // an in-flight turn still completes, so facing follows the commanded direction
        S_TURN_F: begin
          if (bus.goal) begin
            nxt        = S_WIN;
            win_nxt    = 1'b1;
            facing_nxt = 1'b1;
          end else if (tz) begin
            nxt        = S_WATCH;
            facing_nxt = 1'b1;
            timer_nxt  = WATCH_L;
          end
        end
        S_WATCH: begin
          if (bus.motion) begin
            nxt        = S_CAUGHT;
            caught_nxt = 1'b1;
          end else if (bus.goal) begin
            nxt     = S_WIN;
            win_nxt = 1'b1;
          end else if (tz && round_r == ROUNDS_L) begin
            nxt        = S_CAUGHT;
            caught_nxt = 1'b1;
          end else if (tz) begin
            nxt       = S_TURN_B;
            turn      = 1'b1;
            round_nxt = round_r + 4'd1;
            timer_nxt = TRAVEL_L;
          end
        end
        S_TURN_B: begin
          if (bus.goal) begin
            nxt        = S_WIN;
            win_nxt    = 1'b1;
            facing_nxt = 1'b0;
          end else if (tz) begin
            nxt        = S_SING;
            facing_nxt = 1'b0;
            timer_nxt  = sing_load;
          end
        end
        S_CAUGHT, S_WIN: if (bus.start) leave = 1'b1;
        S_HOME: if (tz) begin
          nxt        = S_IDLE;
          facing_nxt = 1'b0;
          round_nxt  = 4'd0;
        end
        default: nxt = S_IDLE;
      endcase
    end

    if (leave) begin
      if (facing_r) begin
        nxt       = S_HOME;
        turn      = 1'b1;
        timer_nxt = TRAVEL_L;
      end else begin
        nxt       = S_IDLE;
        round_nxt = 4'd0;
        timer_nxt = 32'd0;
      end
    end
  end

  assign bus.turn   = turn;
  assign bus.facing = facing_r;
  assign bus.state  = cur;
  assign bus.round  = round_r;
  assign bus.caught = caught_r;
  assign bus.win    = win_r;

endmodule

// File: tb/tb_doll_sequencer.sv
// Directed bench for doll_sequencer with small timing parameters and an LFSR reference for sing lengths.
module tb_doll_sequencer;

  localparam logic [2:0] IDLE = 3'd0, SING = 3'd1, TURN_F = 3'd2, WATCH = 3'd3,
                         TURN_B = 3'd4, CAUGHT = 3'd5, WIN = 3'd6, HOME = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  doll_if bus ();

  doll_sequencer #(
    .SING_BASE (10),
    .SING_SHIFT(0),
    .TRAVEL    (4),
    .WATCH     (8),
    .ROUNDS    (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int turn_cnt = 0;
  logic [15:0] m_lfsr;

  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  always @(posedge clk) if (bus.turn === 1'b1) turn_cnt <= turn_cnt + 1;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // counts samples spent in state s; lf returns the LFSR value seen just before leaving
  task automatic measure(input logic [2:0] s, output int n, output logic [15:0] lf);
    n = 0;
    lf = m_lfsr;
    while (bus.state === s && n < 1000) begin
      lf = m_lfsr;
      n++;
      tick();
    end
  endtask

  task automatic start_game(output int exp_len);
    exp_len = 10 + int'(m_lfsr[3:0]) + 1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    int n, exp_len, tc;
    logic [15:0] lf;
    bus.start = 1'b0; bus.abort = 1'b0; bus.motion = 1'b0; bus.goal = 1'b0;
    tick(); tick();
    chk("rst_state", bus.state, IDLE);
    chk("rst_round", bus.round, 0);
    chk("rst_turn", bus.turn, 0);
    chk("rst_facing", bus.facing, 0);
    chk("rst_caught", bus.caught, 0);
    chk("rst_win", bus.win, 0);
    rst = 1'b0;
    tick();

    // full game with no player activity: time runs out after round 2
    tc = turn_cnt;
    start_game(exp_len);
    chk("g1_round1", bus.round, 1);
    measure(SING, n, lf);   chk("g1_sing1_len", n, exp_len);
    measure(TURN_F, n, lf); chk("g1_turnf1_len", n, 5);
    chk("g1_facing_watch", bus.facing, 1);
    measure(WATCH, n, lf);  chk("g1_watch1_len", n, 9);
    chk("g1_round2", bus.round, 2);
    measure(TURN_B, n, lf); chk("g1_turnb_len", n, 5);
    exp_len = 10 + int'(lf[3:0]) + 1;
    chk("g1_facing_sing2", bus.facing, 0);
    measure(SING, n, lf);   chk("g1_sing2_len", n, exp_len);
    measure(TURN_F, n, lf); chk("g1_turnf2_len", n, 5);
    measure(WATCH, n, lf);  chk("g1_watch2_len", n, 9);
    chk("g1_end_state", bus.state, CAUGHT);
    chk("g1_end_round", bus.round, 2);
    chk("g1_end_caught", bus.caught, 1);
    chk("g1_end_facing", bus.facing, 1);
    chk("g1_turns", turn_cnt - tc, 3);

    // acknowledge from CAUGHT while facing: homing turn then IDLE
    tc = turn_cnt;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("home_state", bus.state, HOME);
    measure(HOME, n, lf);   chk("home_len", n, 5);
    chk("home_idle", bus.state, IDLE);
    chk("home_facing", bus.facing, 0);
    chk("home_round", bus.round, 0);
    chk("home_turns", turn_cnt - tc, 1);

    // motion ignored in SING/TURN_F, caught in WATCH cycle 3
    start_game(exp_len);
    bus.motion = 1'b1;
    measure(SING, n, lf);   chk("mot_sing_len", n, exp_len);
    measure(TURN_F, n, lf); chk("mot_turnf_len", n, 5);
    bus.motion = 1'b0;
    tick(); tick();
    chk("mot_watch3", bus.state, WATCH);
    bus.motion = 1'b1; tick(); bus.motion = 1'b0;
    chk("mot_caught_state", bus.state, CAUGHT);
    chk("mot_caught_flag", bus.caught, 1);
    chk("mot_win_flag", bus.win, 0);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    measure(HOME, n, lf);
    chk("mot_back_idle", bus.state, IDLE);

    // motion and goal together in WATCH: motion wins
    start_game(exp_len);
    measure(SING, n, lf);
    measure(TURN_F, n, lf);
    bus.motion = 1'b1; bus.goal = 1'b1; tick(); bus.motion = 1'b0; bus.goal = 1'b0;
    chk("mg_state", bus.state, CAUGHT);
    chk("mg_win", bus.win, 0);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    measure(HOME, n, lf);

    // goal in SING: WIN while facing away, acknowledge goes straight to IDLE
    start_game(exp_len);
    bus.goal = 1'b1; tick(); bus.goal = 1'b0;
    chk("goal_state", bus.state, WIN);
    chk("goal_win", bus.win, 1);
    chk("goal_caught", bus.caught, 0);
    chk("goal_facing", bus.facing, 0);
    tc = turn_cnt;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("goal_idle", bus.state, IDLE);
    chk("goal_round", bus.round, 0);
    chk("goal_no_turn", turn_cnt - tc, 0);

    // abort in WATCH: homing turn, flags cleared
    start_game(exp_len);
    measure(SING, n, lf);
    measure(TURN_F, n, lf);
    tick();
    tc = turn_cnt;
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    chk("abort_state", bus.state, HOME);
    chk("abort_caught", bus.caught, 0);
    chk("abort_win", bus.win, 0);
    chk("abort_turns", turn_cnt - tc, 1);
    measure(HOME, n, lf);   chk("abort_home_len", n, 5);

    // asynchronous reset in the middle of TURN_F
    start_game(exp_len);
    measure(SING, n, lf);
    tick(); tick();
    chk("arst_pre_state", bus.state, TURN_F);
    tc = turn_cnt;
    #2 rst = 1'b1;
    #1;
    chk("arst_state", bus.state, IDLE);
    chk("arst_round", bus.round, 0);
    chk("arst_turn", bus.turn, 0);
    chk("arst_facing", bus.facing, 0);
    chk("arst_caught", bus.caught, 0);
    chk("arst_win", bus.win, 0);
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    chk("arst_no_turn", turn_cnt - tc, 0);
    chk("arst_idle", bus.state, IDLE);

    // sing duration over 16 games follows the LFSR
    for (int g = 0; g < 16; g++) begin
      start_game(exp_len);
      measure(SING, n, lf);
      chk($sformatf("sing_len_%0d", g), n, exp_len);
      chk($sformatf("sing_range_%0d", g), (n >= 11 && n <= 26), 1);
      bus.abort = 1'b1; tick(); bus.abort = 1'b0;
      chk($sformatf("sing_abort_idle_%0d", g), bus.state, IDLE);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
